// File: rtl/axil2wb_pkg.sv
// Shared types and constants for the AXI4-Lite to Wishbone bridge.
package axil2wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CYC,
    ST_WR_RESP,
    ST_RD_CYC,
    ST_RD_RESP
  } state_e;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF;

endpackage

// File: rtl/axil2wb_if.sv
// AXI4-Lite and classic Wishbone B4 bus bundles used by the bridge.
interface axil_if #(parameter int unsigned AW = 12);
  logic          awvalid, awready;
  logic [AW-1:0] awaddr;
  logic          wvalid, wready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic          rvalid, rready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

interface wb_if;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );
  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/axil2wb_timeout.sv
// Ack-wait watchdog: down-counter reloaded while clr is high, expires at zero while en is high.
module axil2wb_timeout #(
  parameter int pTIMEOUT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = ($clog2(pTIMEOUT + 1) > 8) ? $clog2(pTIMEOUT + 1) : 8;
  localparam logic [CW-1:0] RELOAD = CW'(pTIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = RELOAD;
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) cnt_q <= RELOAD;
    else          cnt_q <= cnt_d;
  end

  // Reloaded in IDLE, so the first strobe cycle sees pTIMEOUT-1 and the last sees 0.
  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/axil2wb_master.sv
// AXI4-Lite slave to classic Wishbone master bridge, one transaction outstanding.
// Optional ack timeout with SLVERR response when AXIL2WB_TIMEOUT_EN is defined.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | offer ready (write beats read), accept on handshake
// ST_WR_CYC  | WB write cycle driven, waiting for ack
// ST_WR_RESP | bvalid held until bready
// ST_RD_CYC  | WB read cycle driven, waiting for ack
// ST_RD_RESP | rvalid/rdata held until rready
module axil2wb_master
  import axil2wb_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter logic [31:0] pBASE_ADDR  = 32'h3000_0000,
  parameter int          pTIMEOUT    = 255
) (
  input  logic  wb_clk_i,
  input  logic  wb_rst_i,
  axil_if.slave axil,
  wb_if.master  wb
);

  state_e                 state_q, state_d;
  logic                   awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic                   bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]             bresp_q, bresp_d, rresp_q, rresp_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d, dat_q, dat_d;
  logic                   cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [3:0]             sel_q, sel_d;
  logic [31:0]            adr_q, adr_d;
  logic                   wr_elig, tmo_expired;

`ifdef AXIL2WB_TIMEOUT_EN
  axil2wb_timeout #(.pTIMEOUT(pTIMEOUT)) u_timeout (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clr      (state_q == ST_IDLE),
    .en       (cyc_q),
    .expired  (tmo_expired)
  );
`else
  // No watchdog in this build: pTIMEOUT is ignored and the bridge waits forever.
  assign tmo_expired = (pTIMEOUT < 0);
`endif

  assign wr_elig = axil.awvalid && axil.wvalid;

  always_comb begin
    state_d   = state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    arready_d = arready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    case (state_q)
      ST_IDLE: begin
        if (awready_q && wr_elig) begin
          awready_d = 1'b0;
          wready_d  = 1'b0;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          we_d      = 1'b1;
          sel_d     = axil.wstrb;
          adr_d     = {pBASE_ADDR[31:pADDR_WIDTH], axil.awaddr};
          dat_d     = axil.wdata;
          state_d   = ST_WR_CYC;
        end else if (arready_q && axil.arvalid) begin
          arready_d = 1'b0;
          cyc_d     = 1'b1;
          stb_d     = 1'b1;
          we_d      = 1'b0;
          sel_d     = 4'hF;
          adr_d     = {pBASE_ADDR[31:pADDR_WIDTH], axil.araddr};
          state_d   = ST_RD_CYC;
        end else begin
          awready_d = wr_elig;
          wready_d  = wr_elig;
          arready_d = axil.arvalid && !wr_elig;
        end
      end
      ST_WR_CYC: begin
        if (wb.wbm_ack_i || tmo_expired) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          we_d     = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = wb.wbm_ack_i ? RESP_OKAY : RESP_SLVERR;
          state_d  = ST_WR_RESP;
        end
      end
      ST_RD_CYC: begin
        if (wb.wbm_ack_i || tmo_expired) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = wb.wbm_ack_i ? wb.wbm_dat_i : ERR_RDATA;
          rresp_d  = wb.wbm_ack_i ? RESP_OKAY : RESP_SLVERR;
          state_d  = ST_RD_RESP;
        end
      end
      // Ready is offered on the handshake edge so the next request is taken one cycle later.
      ST_WR_RESP, ST_RD_RESP: begin
        if ((state_q == ST_WR_RESP) ? axil.bready : axil.rready) begin
          bvalid_d  = 1'b0;
          rvalid_d  = 1'b0;
          awready_d = wr_elig;
          wready_d  = wr_elig;
          arready_d = axil.arvalid && !wr_elig;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
    end
  end

  assign axil.awready = awready_q;
  assign axil.wready  = wready_q;
  assign axil.arready = arready_q;
  assign axil.bvalid  = bvalid_q;
  assign axil.bresp   = bresp_q;
  assign axil.rvalid  = rvalid_q;
  assign axil.rresp   = rresp_q;
  assign axil.rdata   = rdata_q;
  assign wb.wbm_cyc_o = cyc_q;
  assign wb.wbm_stb_o = stb_q;
  assign wb.wbm_we_o  = we_q;
  assign wb.wbm_sel_o = sel_q;
  assign wb.wbm_adr_o = adr_q;
  assign wb.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_axil2wb_master.sv
// Directed self-checking bench for axil2wb_master; AXIL2WB_TIMEOUT_EN selects the timeout scenario.
module tb_axil2wb_master;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  axil_if #(.AW(12)) axil ();
  wb_if              wb ();

  axil2wb_master #(
    .pADDR_WIDTH (12),
    .pDATA_WIDTH (32),
    .pBASE_ADDR  (32'h3000_0000),
    .pTIMEOUT    (TMO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .axil     (axil),
    .wb       (wb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    axil.awvalid = 0; axil.awaddr = '0; axil.wvalid = 0; axil.wdata = '0; axil.wstrb = '0;
    axil.bready = 1; axil.arvalid = 0; axil.araddr = '0; axil.rready = 1;
    wb.wbm_ack_i = 0; wb.wbm_dat_i = '0;

    // Reset values
    tick(); tick();
    chk1("rst_awready", axil.awready, 1'b0);
    chk1("rst_wready", axil.wready, 1'b0);
    chk1("rst_arready", axil.arready, 1'b0);
    chk1("rst_bvalid", axil.bvalid, 1'b0);
    chk1("rst_rvalid", axil.rvalid, 1'b0);
    chk1("rst_cyc", wb.wbm_cyc_o, 1'b0);
    chk1("rst_stb", wb.wbm_stb_o, 1'b0);
    chk1("rst_we", wb.wbm_we_o, 1'b0);
    chk32("rst_sel", 32'(wb.wbm_sel_o), 32'h0);
    chk32("rst_adr", wb.wbm_adr_o, 32'h0);
    chk32("rst_dat_o", wb.wbm_dat_o, 32'h0);
    chk32("rst_rdata", axil.rdata, 32'h0);
    chk32("rst_bresp", 32'(axil.bresp), 32'h0);
    chk32("rst_rresp", 32'(axil.rresp), 32'h0);
    rst = 0;
    tick();

    // Basic write, ack after two strobe cycles
    axil.awvalid = 1; axil.wvalid = 1; axil.awaddr = 12'h020; axil.wdata = 32'h0000_0007; axil.wstrb = 4'hF;
    tick();
    chk1("w1_awready", axil.awready, 1'b1);
    chk1("w1_wready", axil.wready, 1'b1);
    tick();
    axil.awvalid = 0; axil.wvalid = 0;
    chk1("w1_awready_drop", axil.awready, 1'b0);
    chk1("w1_cyc", wb.wbm_cyc_o, 1'b1);
    chk1("w1_stb", wb.wbm_stb_o, 1'b1);
    chk1("w1_we", wb.wbm_we_o, 1'b1);
    chk32("w1_sel", 32'(wb.wbm_sel_o), 32'hF);
    chk32("w1_adr", wb.wbm_adr_o, 32'h3000_0020);
    chk32("w1_dat_o", wb.wbm_dat_o, 32'h0000_0007);
    chk1("w1_bvalid_early", axil.bvalid, 1'b0);
    tick();
    chk1("w1_stb_2nd", wb.wbm_stb_o, 1'b1);
    wb.wbm_ack_i = 1;
    tick();
    wb.wbm_ack_i = 0;
    chk1("w1_stb_after_ack", wb.wbm_stb_o, 1'b0);
    chk1("w1_cyc_after_ack", wb.wbm_cyc_o, 1'b0);
    chk1("w1_we_after_ack", wb.wbm_we_o, 1'b0);
    chk1("w1_bvalid", axil.bvalid, 1'b1);
    chk32("w1_bresp", 32'(axil.bresp), 32'h0);
    tick();
    chk1("w1_bvalid_done", axil.bvalid, 1'b0);

    // Basic read
    axil.arvalid = 1; axil.araddr = 12'h084;
    tick();
    chk1("r1_arready", axil.arready, 1'b1);
    chk1("r1_awready", axil.awready, 1'b0);
    tick();
    axil.arvalid = 0;
    chk1("r1_arready_drop", axil.arready, 1'b0);
    chk1("r1_stb", wb.wbm_stb_o, 1'b1);
    chk1("r1_we", wb.wbm_we_o, 1'b0);
    chk32("r1_sel", 32'(wb.wbm_sel_o), 32'hF);
    chk32("r1_adr", wb.wbm_adr_o, 32'h3000_0084);
    tick();
    chk1("r1_arready_cyc", axil.arready, 1'b0);
    wb.wbm_ack_i = 1; wb.wbm_dat_i = 32'h1234_5678;
    tick();
    wb.wbm_ack_i = 0; wb.wbm_dat_i = '0;
    chk1("r1_rvalid", axil.rvalid, 1'b1);
    chk32("r1_rdata", axil.rdata, 32'h1234_5678);
    chk32("r1_rresp", 32'(axil.rresp), 32'h0);
    chk1("r1_stb_after_ack", wb.wbm_stb_o, 1'b0);
    tick();
    chk1("r1_rvalid_done", axil.rvalid, 1'b0);

    // Simultaneous write and read: write first, read taken one cycle after bready handshake
    axil.awvalid = 1; axil.wvalid = 1; axil.awaddr = 12'h040; axil.wdata = 32'hAAAA_5555; axil.wstrb = 4'h3;
    axil.arvalid = 1; axil.araddr = 12'h0C8;
    tick();
    chk1("s_awready", axil.awready, 1'b1);
    chk1("s_arready_blocked", axil.arready, 1'b0);
    tick();
    axil.awvalid = 0; axil.wvalid = 0;
    chk1("s_we", wb.wbm_we_o, 1'b1);
    chk32("s_adr_w", wb.wbm_adr_o, 32'h3000_0040);
    chk32("s_sel_w", 32'(wb.wbm_sel_o), 32'h3);
    chk1("s_arready_wcyc", axil.arready, 1'b0);
    wb.wbm_ack_i = 1;
    tick();
    wb.wbm_ack_i = 0;
    chk1("s_bvalid", axil.bvalid, 1'b1);
    chk1("s_arready_wresp", axil.arready, 1'b0);
    tick();
    chk1("s_bvalid_done", axil.bvalid, 1'b0);
    chk1("s_arready_after_hs", axil.arready, 1'b1);
    tick();
    axil.arvalid = 0;
    chk1("s_rd_stb", wb.wbm_stb_o, 1'b1);
    chk1("s_rd_we", wb.wbm_we_o, 1'b0);
    chk32("s_rd_adr", wb.wbm_adr_o, 32'h3000_00C8);
    wb.wbm_ack_i = 1; wb.wbm_dat_i = 32'h0BAD_F00D;
    tick();
    wb.wbm_ack_i = 0; wb.wbm_dat_i = '0;
    chk32("s_rdata", axil.rdata, 32'h0BAD_F00D);
    tick();

    // bready held low for 5 cycles; wstrb=0 write; read pending meanwhile
    axil.bready = 0;
    axil.awvalid = 1; axil.wvalid = 1; axil.awaddr = 12'h0FC; axil.wdata = 32'h1122_3344; axil.wstrb = 4'h0;
    tick(); tick();
    axil.awvalid = 0; axil.wvalid = 0;
    chk1("h_we", wb.wbm_we_o, 1'b1);
    chk32("h_sel_zero", 32'(wb.wbm_sel_o), 32'h0);
    chk32("h_dat_o", wb.wbm_dat_o, 32'h1122_3344);
    wb.wbm_ack_i = 1;
    tick();
    wb.wbm_ack_i = 0;
    axil.arvalid = 1; axil.araddr = 12'h010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("h_bvalid_hold", axil.bvalid, 1'b1);
      chk32("h_bresp_hold", 32'(axil.bresp), 32'h0);
      chk1("h_cyc_low", wb.wbm_cyc_o, 1'b0);
      chk1("h_arready_low", axil.arready, 1'b0);
    end
    axil.bready = 1;
    tick();
    chk1("h_bvalid_done", axil.bvalid, 1'b0);
    chk1("h_arready", axil.arready, 1'b1);
    tick();
    axil.arvalid = 0;
    chk32("h_rd_adr", wb.wbm_adr_o, 32'h3000_0010);
    wb.wbm_ack_i = 1; wb.wbm_dat_i = 32'hCAFE_0001;
    tick();
    wb.wbm_ack_i = 0; wb.wbm_dat_i = '0;
    chk32("h_rdata", axil.rdata, 32'hCAFE_0001);
    tick();

    // Stray ack while idle is ignored
    wb.wbm_ack_i = 1;
    tick();
    wb.wbm_ack_i = 0;
    tick();
    chk1("idle_ack_bvalid", axil.bvalid, 1'b0);
    chk1("idle_ack_rvalid", axil.rvalid, 1'b0);
    chk1("idle_ack_cyc", wb.wbm_cyc_o, 1'b0);

    // Read with no ack: timeout build returns SLVERR, default build waits
    axil.arvalid = 1; axil.araddr = 12'h100;
    tick(); tick();
    axil.arvalid = 0;
    n = 0;
    while (wb.wbm_stb_o && n < 40) begin
      n++;
      tick();
    end
`ifdef AXIL2WB_TIMEOUT_EN
    chk32("tmo_stb_cycles", n, TMO);
    chk1("tmo_rvalid", axil.rvalid, 1'b1);
    chk32("tmo_rresp", 32'(axil.rresp), 32'h2);
    chk32("tmo_rdata", axil.rdata, 32'hDEAD_BEEF);
    tick();
`else
    chk32("wait_stb_cycles", n, 40);
    chk1("wait_stb_still", wb.wbm_stb_o, 1'b1);
    chk1("wait_rvalid_low", axil.rvalid, 1'b0);
    wb.wbm_ack_i = 1; wb.wbm_dat_i = 32'h5A5A_A5A5;
    tick();
    wb.wbm_ack_i = 0; wb.wbm_dat_i = '0;
    chk1("wait_rvalid", axil.rvalid, 1'b1);
    chk32("wait_rresp", 32'(axil.rresp), 32'h0);
    chk32("wait_rdata", axil.rdata, 32'h5A5A_A5A5);
    tick();
`endif
    chk1("post_rd_rvalid", axil.rvalid, 1'b0);

    // Reset pulsed during a read cycle
    axil.arvalid = 1; axil.araddr = 12'h200;
    tick(); tick();
    axil.arvalid = 0;
    tick();
    chk1("rr_stb_before", wb.wbm_stb_o, 1'b1);
    #2;
    rst = 1;
    #1;
    chk1("rr_cyc_async", wb.wbm_cyc_o, 1'b0);
    chk1("rr_stb_async", wb.wbm_stb_o, 1'b0);
    tick();
    rst = 0;
    wb.wbm_ack_i = 1;
    tick();
    wb.wbm_ack_i = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("rr_no_rvalid", axil.rvalid, 1'b0);
      chk1("rr_cyc_low", wb.wbm_cyc_o, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil2wb_master.md
# axil2wb_master

AXI4-Lite slave to Wishbone master bridge: the reverse of the team's Wishbone-to-AXI adapter. An AXI-Lite initiator (test sequencer or DMA engine) issues register reads and writes; the block converts each into one classic Wishbone B4 cycle on the user-project bus and returns the AXI response. One transaction is outstanding at a time.

## Interface
- pADDR_WIDTH, 12, AXI-Lite address width; forms the low bits of the WB address
- pDATA_WIDTH, 32, data width for both buses; must be 32
- pBASE_ADDR, 32'h3000_0000, base address; supplies WB address bits [31:pADDR_WIDTH]
- pTIMEOUT, 255, maximum wait for ack, in cycles (used only with the timeout feature)
- wb_clk_i  in  1  clock for all logic
- wb_rst_i  in  1  asynchronous, active-high reset
- awvalid / awready  in / out  1  write-address handshake
- awaddr  in  pADDR_WIDTH  write address
- wvalid / wready  in / out  1  write-data handshake
- wdata  in  32  write data
- wstrb  in  4  byte strobes
- bvalid / bready  out / in  1  write-response handshake
- bresp  out  2  write response: 00 OKAY, 10 SLVERR
- arvalid / arready  in / out  1  read-address handshake
- araddr  in  pADDR_WIDTH  read address
- rvalid / rready  out / in  1  read-data handshake
- rdata  out  32  read data
- rresp  out  2  read response
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone cycle, strobe and write-enable
- wbm_sel_o  out  4  byte selects
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge

## Operation
- FSM states: IDLE, WR_CYC, WR_RESP, RD_CYC, RD_RESP.
- IDLE, write path:
  - awready and wready are high only when awvalid and wvalid are both high.
  - AW and W are accepted in the same cycle; addr, data and strobes are latched. Go to WR_CYC.
- IDLE, read path: arready is asserted when arvalid is high and no write is eligible. Latch the address; go to RD_CYC.
- Simultaneous write and read eligible: write wins. The read stays pending with arready low.
- WR_CYC:
  - Drive cyc=stb=we=1, sel=latched wstrb, adr={pBASE_ADDR[31:pADDR_WIDTH], addr}, dat_o=latched data.
  - On ack: drop cyc/stb/we next edge, assert bvalid with bresp=00, go to WR_RESP.
- RD_CYC:
  - Drive cyc=stb=1, we=0, sel=4'hF.
  - On ack: capture wbm_dat_i into rdata, assert rvalid with rresp=00, go to RD_RESP.
- WR_RESP / RD_RESP: hold bvalid/rvalid and their payload stable until bready/rready is high. Then return to IDLE.
- wstrb=0 still produces a WB write cycle, with sel=0.
- Address wrap: awaddr/araddr are never incremented. There is no wrap logic.

## Timing
- Reset values: every ready, valid, cyc, stb and we output is 0; sel, adr, dat_o and rdata are 0; bresp and rresp are 00.
- Every output is registered. No combinational path from an AXI input to a WB output.
- Accept at edge N; stb is high from cycle N+1.
- ack sampled high at edge K; stb is low and bvalid/rvalid are high from K+1.
- Minimum write: 3 cycles from acceptance to bvalid, given ack in the first stb cycle and bready held high.
- Next transaction can be accepted one cycle after the response handshake.
- ack while cyc is low is ignored.
- Reset asserted mid-transaction: the cycle is aborted immediately (async) and the transaction is lost. The FSM goes to IDLE with no response.

## Configuration
- AXIL2WB_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter runs during WR_CYC/RD_CYC.
  - If it reaches pTIMEOUT without ack, cyc/stb drop next edge and the response uses SLVERR (2'b10).
  - On a timed-out read, rdata = 32'hDEAD_BEEF.
  - The counter clears at every cycle start.
- AXIL2WB_TIMEOUT_EN undefined: the block waits indefinitely, and the response is always OKAY.

## Structure
- Package axil2wb_pkg holds:
  - state enum (5 states)
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - ERR_RDATA = 32'hDEAD_BEEF
- Natural sub-module: axil2wb_timeout, the counter plus expiry flag. It is instantiated only under AXIL2WB_TIMEOUT_EN.

## Test plan
- Write awaddr=12'h020, wdata=32'h0000_0007, wstrb=4'hF, ack after 2 cycles -> WB adr=32'h3000_0020, we=1, sel=F, dat_o=7; bvalid with bresp=00.
- Read araddr=12'h084, slave returns 32'h1234_5678 on ack -> rdata=32'h1234_5678, rresp=00, arready low during the cycle.
- awvalid, wvalid and arvalid all raised in the same cycle -> write is serviced first; the read is accepted one cycle after the bready handshake.
- bready held low for 5 cycles after bvalid -> bvalid and bresp stable, no new acceptance, and cyc stays low.
- With AXIL2WB_TIMEOUT_EN, pTIMEOUT=16, ack never arrives on a read -> stb drops after 16 cycles, rresp=10, rdata=32'hDEAD_BEEF.
- wb_rst_i pulsed during RD_CYC -> cyc/stb drop asynchronously, and no rvalid appears afterwards.
